spi_frame_arbiter: RTL and testbench
====================================

// Module: spi_frame_arbiter
// PURPOSE
// Shares one SPI_Serializer between NREQ requesters. Grants frames round-robin,
// loads the winning 32-bit word, asserts the serializer load strobe and tracks
// chip-select until the frame ends. Enforces a minimum inter-frame gap and a
// start timeout. Sits between requesting blocks and the serializer instance.
// PARAMETERS
// NREQ        4    number of requesters (2..8)
// LD_HOLD     25   cycles ld is held high per frame (>=1)
// GAP_CYCLES  8    idle cycles after CS deasserts before the next grant (>=0)
// START_TMO   64   cycles to wait for CS to assert after ld rises
// PORTS
// clk           in   1        system clock, rising edge
// rst           in   1        asynchronous, active-high reset
// req_valid     in   NREQ     requester i has a frame pending
// req_data      in   32*NREQ  frame word i = req_data[32*i +: 32]
// req_ready     out  NREQ     one-hot; one-cycle accept pulse for granted requester
// ser_data      out  32       to serializer Data_Register
// ser_ld        out  1        to serializer ld
// ser_cs        in   1        from serializer CS; low while shifting
// grant_id      out  $clog2(NREQ)  index of current/last granted requester
// busy          out  1        high in any state except IDLE
// frame_done    out  1        one-cycle pulse when CS returns high
// err_timeout   out  1        sticky; set on start timeout, cleared only by rst
// BEHAVIOUR
// - Reset: state IDLE, req_ready=0, ser_data=0, ser_ld=0, grant_id=0,
//   busy=0, frame_done=0, err_timeout=0, rr pointer=0. Reset mid-frame drops
//   ser_ld at once; the in-flight frame is abandoned, nothing replayed.
// - FSM: IDLE -> LOAD -> WAIT_START -> SHIFT -> GAP -> IDLE.
// - IDLE: if any req_valid, pick first valid index at or after rr pointer
//   (wrapping). Same cycle: req_ready[i]=1, latch req_data[i] into ser_data,
//   grant_id<=i, rr pointer<=(i+1) mod NREQ, go LOAD. Requester must hold
//   data valid until req_ready; data may change the cycle after.
// - LOAD: ser_ld=1 for exactly LD_HOLD cycles (first cycle = cycle after
//   grant). ser_data stable throughout LOAD/WAIT_START/SHIFT.
// - Start detection runs from first LOAD cycle: ser_cs sampled low -> SHIFT
//   (may occur during LOAD; ser_ld still completes its LD_HOLD cycles).
// - WAIT_START: entered after LOAD if CS not yet seen low. Timeout counter
//   counts from first LOAD cycle; reaching START_TMO with no CS low sets
//   err_timeout, drops ser_ld, goes GAP (frame counted lost, no frame_done).
// - SHIFT: on ser_cs sampled high (and LD_HOLD done): frame_done=1 one cycle,
//   go GAP. CS glitches are not filtered.
// - GAP: hold GAP_CYCLES cycles, then IDLE. GAP_CYCLES=0 -> IDLE next cycle.
//   Earliest next grant: 1 cycle after GAP ends (grant issued in IDLE).
// - Requesters deasserting req_valid before grant simply lose arbitration;
//   no requests are queued internally. Only one frame outstanding at a time.
// - Counters sized $clog2(max(LD_HOLD,GAP_CYCLES,START_TMO)+1); no wrap.
// STRUCTURE
// - Shared package spi_pkg: state encoding enum (IDLE,LOAD,WAIT_START,SHIFT,
//   GAP), SPI_WORD_W=32 constant.
// - One sub-module: rr_arbiter (NREQ-wide round-robin grant, pointer update
//   on accept). FSM, counters, data latch stay in top.
// TESTING (bench instantiates this block plus SPI_Serializer)
// - Single: req_valid=4'b0001, data 32'h009E6D55 -> req_ready[0] 1 cycle,
//   ser_ld high 25 cycles, ser_data=009E6D55, serial bits match, frame_done once.
// - Fairness: all 4 valid continuously -> grant order 0,1,2,3,0; each
//   req_ready exactly once per 4 frames; gap >= GAP_CYCLES between CS frames.
// - Sparse: only req 2 and 3 valid, pointer at 0 -> grant 2 then 3 then 2.
// - Timeout: tie ser_cs high (stub) -> err_timeout set at cycle 64 after
//   first ld, ser_ld low, FSM returns IDLE after gap; err stays 1 until rst.
// - Reset mid-frame: assert rst during SHIFT -> all outputs 0 immediately,
//   next request after release granted from index 0.
// - Data stability: change req_data after req_ready -> ser_data unchanged
//   until next grant.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame arbiter slice.
//   SPI_WORD_W : width of one serializer frame word
//   state_t    : frame sequencing states
//   max3       : helper used to size the shared cycle counters
package spi_pkg;

  localparam int SPI_WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_START,
    SHIFT,
    GAP
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. The search starts at the pointer and wraps; the pointer
// moves to one past the winner only when the grant is accepted.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   req        : request vector
//   accept     : the current grant is being taken this cycle
//   grant      : one-hot grant (zero when nothing requests)
//   grant_idx  : index of the winning requester
//   any        : at least one request is present
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            accept,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            any
);

  logic [IW-1:0] ptr_reg;
  logic [IW-1:0] cand [NREQ];

  // cand[k] is the requester index at search offset k from the pointer
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
      assign cand[gi] = IW'((int'(ptr_reg) + gi) % NREQ);
    end
  endgenerate

  // Scan from the farthest offset down so the nearest valid one wins last.
  always_comb begin
    any       = 1'b0;
    grant_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        any       = 1'b1;
        grant_idx = cand[k];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
      assign grant[gi] = any && (grant_idx == IW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (accept && any) begin
      ptr_reg <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/spi_frame_arbiter.sv
// Shares one SPI serializer between NREQ requesters. A round-robin winner is
// accepted in IDLE, its word is latched onto ser_data and ser_ld is held for
// LD_HOLD cycles. Chip-select is then tracked until the frame ends, followed
// by a GAP_CYCLES idle gap. If CS never drops within START_TMO cycles of the
// first ld cycle the frame is abandoned and err_timeout latches.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   req_valid    : per-requester frame pending
//   req_data     : packed frame words, word i = req_data[32*i +: 32]
//   req_ready    : one-cycle one-hot accept pulse
//   ser_data     : word presented to the serializer
//   ser_ld       : serializer load strobe
//   ser_cs       : serializer chip-select, low while shifting
//   grant_id     : index of the current/last granted requester
//   busy         : high whenever not IDLE
//   frame_done   : one-cycle pulse when CS returns high after a frame
//   err_timeout  : sticky start-timeout flag
module spi_frame_arbiter
  import spi_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int LD_HOLD    = 25,
  parameter int GAP_CYCLES = 8,
  parameter int START_TMO  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [SPI_WORD_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic [SPI_WORD_W-1:0]      ser_data,
  output logic                       ser_ld,
  input  logic                       ser_cs,
  output logic [$clog2(NREQ)-1:0]    grant_id,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       err_timeout
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(max3(LD_HOLD, GAP_CYCLES, START_TMO) + 1);

  localparam logic [CW-1:0] LD_LAST  = CW'(LD_HOLD - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(START_TMO - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  state_t          state_reg;
  logic [CW-1:0]   ld_cnt_reg;
  logic [CW-1:0]   tmo_cnt_reg;
  logic [CW-1:0]   gap_cnt_reg;

  logic [SPI_WORD_W-1:0] req_word [NREQ];
  logic [NREQ-1:0]       arb_grant;
  logic [IW-1:0]         arb_idx;
  logic                  arb_any;
  logic                  arb_accept;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_word
      assign req_word[gi] = req_data[SPI_WORD_W*gi +: SPI_WORD_W];
    end
  endgenerate

  assign arb_accept = (state_reg == IDLE);

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .accept    (arb_accept),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      ld_cnt_reg  <= '0;
      tmo_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      req_ready   <= '0;
      ser_data    <= '0;
      ser_ld      <= 1'b0;
      grant_id    <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      req_ready  <= '0;
      frame_done <= 1'b0;

      // The ld strobe runs its full length independently of the state, so an
      // early CS fall can move the FSM to SHIFT while ld is still high.
      if (ser_ld) begin
        if (ld_cnt_reg == LD_LAST) ser_ld <= 1'b0;
        else                       ld_cnt_reg <= ld_cnt_reg + CW'(1);
      end

      case (state_reg)
        IDLE: begin
          if (arb_any) begin
            req_ready   <= arb_grant;
            ser_data    <= req_word[arb_idx];
            grant_id    <= arb_idx;
            ser_ld      <= 1'b1;
            ld_cnt_reg  <= '0;
            tmo_cnt_reg <= '0;
            busy        <= 1'b1;
            state_reg   <= LOAD;
          end
        end

        LOAD, WAIT_START: begin
          tmo_cnt_reg <= tmo_cnt_reg + CW'(1);
          if (!ser_cs) begin
            state_reg <= SHIFT;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            // Frame is lost: no frame_done, straight into the gap.
            err_timeout <= 1'b1;
            ser_ld      <= 1'b0;
            if (GAP_CYCLES == 0) begin
              state_reg <= IDLE;
              busy      <= 1'b0;
            end else begin
              state_reg   <= GAP;
              gap_cnt_reg <= '0;
            end
          end else if (state_reg == LOAD && ld_cnt_reg == LD_LAST) begin
            state_reg <= WAIT_START;
          end
        end

        SHIFT: begin
          if (ser_cs && !ser_ld) begin
            frame_done <= 1'b1;
            if (GAP_CYCLES == 0) begin
              state_reg <= IDLE;
              busy      <= 1'b0;
            end else begin
              state_reg   <= GAP;
              gap_cnt_reg <= '0;
            end
          end
        end

        GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + CW'(1);
          end
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_arbiter.sv
// Bench for spi_frame_arbiter. A behavioural serializer stand-in answers each
// ld rising edge by pulling CS low for 32 cycles after a programmable delay,
// shifting ser_data out MSB first. Expected grants come from a plain
// round-robin rule evaluated on the requester mask.
module tb_spi_frame_arbiter;

  localparam int NREQ       = 4;
  localparam int LD_HOLD    = 25;
  localparam int GAP_CYCLES = 8;
  localparam int START_TMO  = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic [31:0]  ser_data;
  logic         ser_ld;
  logic         ser_cs;
  logic [1:0]   grant_id;
  logic         busy;
  logic         frame_done;
  logic         err_timeout;

  always #5 clk = ~clk;

  spi_frame_arbiter #(
    .NREQ(NREQ), .LD_HOLD(LD_HOLD), .GAP_CYCLES(GAP_CYCLES), .START_TMO(START_TMO)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .ser_data(ser_data), .ser_ld(ser_ld), .ser_cs(ser_cs),
    .grant_id(grant_id), .busy(busy), .frame_done(frame_done), .err_timeout(err_timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int m_ptr    = 0;
  logic [31:0] words [4];

  // ---------------- serializer stand-in ----------------
  int          cyc = 0;
  int          start_dly = 0;
  bit          stuck = 1'b0;
  logic        ld_prev;
  int          st_phase, st_dly, st_bit;
  logic [31:0] st_word;
  logic [31:0] sh_arr [64];
  int          sh_wr = 0;
  int          gap_arr [64];
  int          gap_wr = 0;
  int          last_rise;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ser_cs    <= 1'b1;
      ld_prev   <= 1'b0;
      st_phase  <= 0;
      st_dly    <= 0;
      st_bit    <= 0;
      last_rise <= -100000;
    end else begin
      ld_prev <= ser_ld;
      case (st_phase)
        0: if (ser_ld && !ld_prev && !stuck) begin
             st_dly   <= start_dly;
             st_phase <= 1;
           end
        1: if (st_dly == 0) begin
             ser_cs  <= 1'b0;
             st_bit  <= 0;
             st_phase <= 2;
             gap_arr[gap_wr % 64] <= cyc - last_rise;
             gap_wr  <= gap_wr + 1;
           end else begin
             st_dly <= st_dly - 1;
           end
        default: begin
          st_word <= {st_word[30:0], ser_data[31 - st_bit]};
          if (st_bit == 31) begin
            ser_cs    <= 1'b1;
            last_rise <= cyc;
            sh_arr[sh_wr % 64] <= {st_word[30:0], ser_data[0]};
            sh_wr     <= sh_wr + 1;
            st_phase  <= 0;
          end else begin
            st_bit <= st_bit + 1;
          end
        end
      endcase
    end
  end

  // ---------------- reference model ----------------
  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  typedef struct {
    bit          got;
    int          gidx;
    bit          onehot;
    int          gid;
    logic [31:0] gdata;
    int          ldlen;
    int          dones;
    bit          stable;
    bit          ended;
    int          err_at;
    int          end_at;
    logic [31:0] shword;
    bit          have_sh;
    int          rr_cyc;
  } frame_t;

  task automatic load_words();
    for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = words[i];
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
  endtask

  // Waits for one grant, then follows the frame until the arbiter is idle
  // again. After the grant the requester mask becomes next_valid and the
  // granted requester loads a fresh word.
  task automatic do_frame(input logic [3:0] next_valid, output frame_t fr);
    int sh_before;
    sh_before = sh_wr;
    fr.got = 0; fr.gidx = -1; fr.onehot = 0; fr.gid = -1; fr.gdata = 'x;
    fr.ldlen = 0; fr.dones = 0; fr.stable = 1; fr.ended = 0;
    fr.err_at = -1; fr.end_at = -1; fr.shword = 'x; fr.have_sh = 0; fr.rr_cyc = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (req_ready != 4'b0) begin
        fr.got = 1;
        break;
      end
    end
    if (!fr.got) return;
    fr.onehot = $onehot(req_ready);
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) fr.gidx = i;
    fr.gid   = int'(grant_id);
    fr.gdata = ser_data;
    words[fr.gidx] = $urandom;
    load_words();
    req_valid = next_valid;
    for (int t = 0; t < 300; t++) begin
      if (ser_ld) fr.ldlen++;
      if (frame_done) fr.dones++;
      if (req_ready != 4'b0) fr.rr_cyc++;
      if (ser_data !== fr.gdata) fr.stable = 0;
      if (err_timeout && fr.err_at < 0) fr.err_at = t;
      if (!busy) begin
        fr.ended  = 1;
        fr.end_at = t;
        break;
      end
      @(negedge clk);
    end
    fr.have_sh = (sh_wr != sh_before);
    if (fr.have_sh) fr.shword = sh_arr[sh_before % 64];
    $display("frame: req %0d data %h ld %0d done %0d shifted %h err_at %0d end_at %0d",
             fr.gidx, fr.gdata, fr.ldlen, fr.dones, fr.shword, fr.err_at, fr.end_at);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({req_ready, ser_ld, busy, frame_done, err_timeout} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000000", {req_ready, ser_ld, busy, frame_done, err_timeout});
    end
    n_checks++;
    if (ser_data !== 32'h0 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_data: got data %h id %0d expected 0/0", ser_data, grant_id);
    end
    rst = 1'b0;
    m_ptr = 0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_single();
    frame_t fr;
    words[0] = 32'h009E6D55;
    load_words();
    start_dly = 2;
    req_valid = 4'b0001;
    do_frame(4'b0000, fr);
    n_checks++;
    if (!fr.got || fr.gidx != 0 || !fr.onehot || fr.gid != 0) begin
      n_fail++;
      $display("FAIL single_grant: got got=%0d idx=%0d onehot=%0d id=%0d expected 1/0/1/0", fr.got, fr.gidx, fr.onehot, fr.gid);
    end
    n_checks++;
    if (fr.rr_cyc != 1) begin
      n_fail++;
      $display("FAIL single_ready_len: got %0d expected 1", fr.rr_cyc);
    end
    n_checks++;
    if (fr.gdata !== 32'h009E6D55 || !fr.stable) begin
      n_fail++;
      $display("FAIL single_data: got %h stable=%0d expected 009e6d55 stable=1", fr.gdata, fr.stable);
    end
    n_checks++;
    if (fr.ldlen != LD_HOLD) begin
      n_fail++;
      $display("FAIL single_ld_len: got %0d expected %0d", fr.ldlen, LD_HOLD);
    end
    n_checks++;
    if (!fr.have_sh || fr.shword !== 32'h009E6D55) begin
      n_fail++;
      $display("FAIL single_serial: got %h expected 009e6d55", fr.shword);
    end
    n_checks++;
    if (fr.dones != 1 || !fr.ended) begin
      n_fail++;
      $display("FAIL single_done: got %0d ended=%0d expected 1 ended=1", fr.dones, fr.ended);
    end
    m_ptr = 1;
  endtask

  task automatic test_fairness();
    frame_t fr;
    int exp_idx;
    logic [31:0] exp_data;
    int cnt [4];
    int g0, min_gap;
    pulse_reset();
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    g0 = gap_wr;
    req_valid = 4'b1111;
    for (int f = 0; f < 8; f++) begin
      exp_idx  = pick(4'b1111, m_ptr);
      exp_data = words[exp_idx];
      start_dly = $urandom_range(0, 20);
      do_frame(4'b1111, fr);
      if (fr.gidx >= 0) cnt[fr.gidx]++;
      n_checks++;
      if (fr.gidx != exp_idx || fr.gid != exp_idx) begin
        n_fail++;
        $display("FAIL fair_grant[%0d]: got %0d id %0d expected %0d", f, fr.gidx, fr.gid, exp_idx);
      end
      n_checks++;
      if (fr.gdata !== exp_data || fr.shword !== exp_data || fr.dones != 1 || fr.ldlen != LD_HOLD) begin
        n_fail++;
        $display("FAIL fair_frame[%0d]: got data %h shifted %h done %0d ld %0d expected %h/%h/1/%0d",
                 f, fr.gdata, fr.shword, fr.dones, fr.ldlen, exp_data, exp_data, LD_HOLD);
      end
      m_ptr = (exp_idx + 1) % NREQ;
    end
    req_valid = 4'b0000;
    n_checks++;
    if (cnt[0] != 2 || cnt[1] != 2 || cnt[2] != 2 || cnt[3] != 2) begin
      n_fail++;
      $display("FAIL fair_counts: got %0d %0d %0d %0d expected 2 2 2 2", cnt[0], cnt[1], cnt[2], cnt[3]);
    end
    min_gap = 1000000;
    for (int i = g0; i < gap_wr; i++) if (gap_arr[i % 64] < min_gap) min_gap = gap_arr[i % 64];
    n_checks++;
    if (min_gap < GAP_CYCLES) begin
      n_fail++;
      $display("FAIL fair_cs_gap: got %0d expected >= %0d", min_gap, GAP_CYCLES);
    end
  endtask

  task automatic test_sparse();
    frame_t fr;
    int exp_idx;
    pulse_reset();
    req_valid = 4'b1100;
    for (int f = 0; f < 3; f++) begin
      exp_idx = pick(4'b1100, m_ptr);
      start_dly = $urandom_range(0, 30);
      do_frame(4'b1100, fr);
      n_checks++;
      if (fr.gidx != exp_idx) begin
        n_fail++;
        $display("FAIL sparse_grant[%0d]: got %0d expected %0d", f, fr.gidx, exp_idx);
      end
      m_ptr = (exp_idx + 1) % NREQ;
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_timeout();
    frame_t fr;
    int r, exp_idx;
    r = $urandom_range(0, 3);
    exp_idx = pick(4'(1 << r), m_ptr);
    stuck = 1'b1;
    req_valid = 4'(1 << r);
    do_frame(4'b0000, fr);
    n_checks++;
    if (fr.gidx != exp_idx) begin
      n_fail++;
      $display("FAIL tmo_grant: got %0d expected %0d", fr.gidx, exp_idx);
    end
    n_checks++;
    if (fr.err_at != START_TMO) begin
      n_fail++;
      $display("FAIL tmo_err_cycle: got %0d expected %0d", fr.err_at, START_TMO);
    end
    n_checks++;
    if (fr.end_at != START_TMO + GAP_CYCLES || fr.dones != 0 || ser_ld !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_recover: got end %0d done %0d ld %b expected %0d/0/0",
               fr.end_at, fr.dones, ser_ld, START_TMO + GAP_CYCLES);
    end
    m_ptr = (exp_idx + 1) % NREQ;
    stuck = 1'b0;
    start_dly = 5;
    exp_idx = pick(4'b0001, m_ptr);
    req_valid = 4'b0001;
    do_frame(4'b0000, fr);
    n_checks++;
    if (fr.dones != 1 || err_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_sticky: got done %0d err %b expected 1/1", fr.dones, err_timeout);
    end
    m_ptr = (exp_idx + 1) % NREQ;
  endtask

  task automatic test_reset_mid_frame();
    frame_t fr;
    bit seen;
    words[2] = $urandom | 32'h1;
    load_words();
    start_dly = 3;
    req_valid = 4'b0100;
    seen = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (req_ready != 4'b0) req_valid = 4'b0000;
      if (ser_cs === 1'b0) begin
        seen = 1;
        break;
      end
    end
    n_checks++;
    if (!seen || busy !== 1'b1 || grant_id !== 2'd2) begin
      n_fail++;
      $display("FAIL midrst_shift: got seen %0d busy %b id %0d expected 1/1/2", seen, busy, grant_id);
    end
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, ser_ld, busy, frame_done, err_timeout} !== 8'h00 || ser_data !== 32'h0 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got ctrl %b data %h id %0d expected 0/0/0",
               {req_ready, ser_ld, busy, frame_done, err_timeout}, ser_data, grant_id);
    end
    req_valid = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    start_dly = 4;
    do_frame(4'b0000, fr);
    n_checks++;
    if (fr.gidx != 0 || fr.dones != 1) begin
      n_fail++;
      $display("FAIL midrst_regrant: got idx %0d done %0d expected 0/1", fr.gidx, fr.dones);
    end
    m_ptr = 1;
  endtask

  task automatic test_back_to_back();
    frame_t fr;
    int exp_idx;
    logic [31:0] exp_data;
    logic [3:0] cur, nxt;
    cur = 4'($urandom_range(1, 15));
    req_valid = cur;
    for (int f = 0; f < 12; f++) begin
      exp_idx  = pick(cur, m_ptr);
      exp_data = words[exp_idx];
      nxt = 4'($urandom_range(1, 15));
      start_dly = $urandom_range(0, 50);
      do_frame(nxt, fr);
      n_checks++;
      if (fr.gidx != exp_idx) begin
        n_fail++;
        $display("FAIL b2b_grant[%0d]: got %0d expected %0d (mask %b)", f, fr.gidx, exp_idx, cur);
      end
      n_checks++;
      if (fr.gdata !== exp_data || !fr.stable || fr.shword !== exp_data || fr.dones != 1) begin
        n_fail++;
        $display("FAIL b2b_frame[%0d]: got data %h stable %0d shifted %h done %0d expected %h/1/%h/1",
                 f, fr.gdata, fr.stable, fr.shword, fr.dones, exp_data, exp_data);
      end
      m_ptr = (exp_idx + 1) % NREQ;
      cur = nxt;
    end
    req_valid = 4'b0000;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) words[i] = $urandom;
    test_reset();
    test_single();
    test_fairness();
    test_sparse();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
